// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_stage_ctrl
// Description : Instruction-fetch stage controller. Owns the PC register, the
//               imem request/response handshake and the IF/ID pipeline latch.
//               Applies hazard-unit decisions (stall_PC, stall_IFID,
//               flush_IFID) and the resolved PCSrc redirect. A one-entry skid
//               buffer keeps a word that returns while decode is stalled, so
//               that word is never fetched twice.
// Options     : FETCH_PERF_EN - when defined, adds the fetch_count and
//               stall_cycles performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_ctrl #(
  parameter int                 WORD_W  = 32,
  parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  // imem handshake
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  // hazard unit
  input  logic              stall_PC,
  input  logic              stall_IFID,
  input  logic              flush_IFID,
  // redirect sources
  input  logic [1:0]        PCSrc,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [WORD_W-1:0] jump_target,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              halt,
  // IF/ID latch
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_cycles
`endif
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0]        state;
  logic [WORD_W-1:0] pc;

  // Skid entry: the word returned on the cycle decode could not accept it.
  logic              skid_valid;
  logic [WORD_W-1:0] skid_instr;
  logic [WORD_W-1:0] skid_npc;

  // Set when the skid word was captured while stall_PC held the PC, so the
  // PC still points at the skid word's own address and must step past it
  // when the skid drains (otherwise that word would be fetched again).
  logic              skid_pc_pending;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  logic [1:0]        next_state;
  logic [WORD_W-1:0] next_pc;
  logic              next_skid_valid;
  logic [WORD_W-1:0] next_skid_instr;
  logic [WORD_W-1:0] next_skid_npc;
  logic              next_skid_pc_pending;
  logic              next_ifid_valid;
  logic [WORD_W-1:0] next_ifid_instr;
  logic [WORD_W-1:0] next_ifid_npc;

  logic [WORD_W-1:0] pc_plus4;
  logic              redirect;
  logic [WORD_W-1:0] redirect_target;

  // Sequential successor wraps silently at 2^WORD_W.
  assign pc_plus4 = pc + WORD_W'(4);
  assign redirect = (PCSrc != SRC_SEQ);

  // Select the redirect destination resolved by later stages.
  always_comb begin
    redirect_target = jr_target;
    case (PCSrc)
      SRC_BRANCH: redirect_target = branch_target;
      SRC_JUMP:   redirect_target = jump_target;
      default:    redirect_target = jr_target;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch request: only FETCH issues requests; reset forces the idle address.
  // --------------------------------------------------------------------------
  assign imemREN  = (state == ST_FETCH) && !RST;
  assign imemaddr = RST ? PC_INIT : pc;

  // Next-state logic: halt outranks redirect/flush, which outrank stalls.
  always_comb begin
    next_state           = state;
    next_pc              = pc;
    next_skid_valid      = skid_valid;
    next_skid_instr      = skid_instr;
    next_skid_npc        = skid_npc;
    next_skid_pc_pending = skid_pc_pending;
    next_ifid_valid      = ifid_valid;
    next_ifid_instr      = ifid_instr;
    next_ifid_npc        = ifid_npc;

    if (halt) begin
      // Stop fetching for good; PC is frozen and everything in flight dies.
      next_state           = ST_HALTED;
      next_skid_valid      = 1'b0;
      next_skid_instr      = '0;
      next_skid_npc        = '0;
      next_skid_pc_pending = 1'b0;
      next_ifid_valid      = 1'b0;
      next_ifid_instr      = '0;
      next_ifid_npc        = '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // PC: a redirect always wins; otherwise advance on an accepted hit.
          if (redirect) begin
            next_pc = redirect_target;
          end else if (ihit && !stall_PC) begin
            next_pc = pc_plus4;
          end

          if (ihit) begin
            if (flush_IFID) begin
              // Returned word is on the wrong path: discard it.
              next_ifid_valid = 1'b0;
              next_ifid_instr = '0;
              next_ifid_npc   = '0;
            end else if (stall_IFID) begin
              // Decode cannot take it: park it in the skid and stop fetching.
              next_skid_valid      = 1'b1;
              next_skid_instr      = imemload;
              next_skid_npc        = pc_plus4;
              next_skid_pc_pending = !redirect && stall_PC;
              next_state           = ST_HOLD;
            end else begin
              next_ifid_valid = 1'b1;
              next_ifid_instr = imemload;
              next_ifid_npc   = pc_plus4;
            end
          end else if (flush_IFID || !stall_IFID) begin
            // Nothing returned: IF/ID becomes a bubble unless decode holds it.
            next_ifid_valid = 1'b0;
            next_ifid_instr = '0;
            next_ifid_npc   = '0;
          end
        end

        ST_HOLD: begin
          // PC is frozen here except for a redirect.
          if (redirect) begin
            next_pc              = redirect_target;
            next_skid_pc_pending = 1'b0;
          end

          if (flush_IFID) begin
            // Skid word is squashed; resume fetching at the current PC.
            next_skid_valid      = 1'b0;
            next_skid_instr      = '0;
            next_skid_npc        = '0;
            next_skid_pc_pending = 1'b0;
            next_ifid_valid      = 1'b0;
            next_ifid_instr      = '0;
            next_ifid_npc        = '0;
            next_state           = ST_FETCH;
          end else if (!stall_IFID) begin
            // Drain the skid into IF/ID instead of re-fetching it.
            next_ifid_valid      = skid_valid;
            next_ifid_instr      = skid_instr;
            next_ifid_npc        = skid_npc;
            next_skid_valid      = 1'b0;
            next_skid_instr      = '0;
            next_skid_npc        = '0;
            next_skid_pc_pending = 1'b0;
            next_state           = ST_FETCH;
            if (!redirect && skid_pc_pending) begin
              next_pc = skid_npc;
            end
          end
        end

        ST_HALTED: begin
          // Only reset leaves this state; keep the latch empty.
          next_ifid_valid = 1'b0;
          next_ifid_instr = '0;
          next_ifid_npc   = '0;
        end

        default: begin
          // Unused encoding: recover to a clean fetch.
          next_state           = ST_FETCH;
          next_skid_valid      = 1'b0;
          next_skid_pc_pending = 1'b0;
          next_ifid_valid      = 1'b0;
          next_ifid_instr      = '0;
          next_ifid_npc        = '0;
        end
      endcase
    end
  end

  // Register update; reset abandons any outstanding request and the skid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= ST_FETCH;
      pc              <= PC_INIT;
      skid_valid      <= 1'b0;
      skid_instr      <= '0;
      skid_npc        <= '0;
      skid_pc_pending <= 1'b0;
      ifid_valid      <= 1'b0;
      ifid_instr      <= '0;
      ifid_npc        <= '0;
    end else begin
      state           <= next_state;
      pc              <= next_pc;
      skid_valid      <= next_skid_valid;
      skid_instr      <= next_skid_instr;
      skid_npc        <= next_skid_npc;
      skid_pc_pending <= next_skid_pc_pending;
      ifid_valid      <= next_ifid_valid;
      ifid_instr      <= next_ifid_instr;
      ifid_npc        <= next_ifid_npc;
    end
  end

`ifdef FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // --------------------------------------------------------------------------
  logic fetch_event;
  logic stall_event;

  assign fetch_event = (state == ST_FETCH) && ihit && !halt;
  assign stall_event = (state == ST_HOLD) || ((state == ST_FETCH) && stall_IFID);

  // Count accepted fetch responses and decode-stall cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (fetch_event) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall_event) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_stage_ctrl
// Description : Directed bench for fetch_stage_ctrl. Stimulus pushes expected
//               IF/ID contents into a queue; a negedge monitor pops and
//               compares whenever ifid_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage_ctrl;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ihit;
  logic [W-1:0]  imemload;
  logic          imemREN;
  logic [W-1:0]  imemaddr;
  logic          stall_PC;
  logic          stall_IFID;
  logic          flush_IFID;
  logic [1:0]    PCSrc;
  logic [W-1:0]  branch_target;
  logic [W-1:0]  jump_target;
  logic [W-1:0]  jr_target;
  logic          halt;
  logic          ifid_valid;
  logic [W-1:0]  ifid_instr;
  logic [W-1:0]  ifid_npc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] instr;
    logic [W-1:0] npc;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage_ctrl #(
    .WORD_W  (W),
    .PC_INIT (32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .stall_PC      (stall_PC),
    .stall_IFID    (stall_IFID),
    .flush_IFID    (flush_IFID),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .halt          (halt),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_npc      (ifid_npc)
  );

  always #5 CLK = ~CLK;

  // Memory image: each word tags its own address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  always_comb imemload = mem_word(imemaddr);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.npc   = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic h, input logic sp, input logic si,
                       input logic fl, input logic [1:0] src);
    ihit       = h;
    stall_PC   = sp;
    stall_IFID = si;
    flush_IFID = fl;
    PCSrc      = src;
  endtask

  // Check the request of the current cycle, then advance one clock.
  task automatic cyc(input string name, input logic [W-1:0] exp_addr, input logic exp_ren);
    #1;
    chk({name, " imemaddr"}, imemaddr, exp_addr);
    chk({name, " imemREN"}, {31'b0, imemREN}, {31'b0, exp_ren});
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, " ifid_valid"}, {31'b0, ifid_valid}, 32'd0);
    chk({name, " ifid_instr"}, ifid_instr, 32'd0);
  endtask

  // Monitor: every valid IF/ID presentation must match the next expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (ifid_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifid unexpected: got instr %h npc %h, expected no valid entry",
                 ifid_instr, ifid_npc);
      end else begin
        e = exp_q.pop_front();
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_npc", ifid_npc, e.npc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    RST = 1'b1;
    halt = 1'b0;
    branch_target = '0;
    jump_target   = '0;
    jr_target     = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge CLK);
    #1;

    // Reset state
    cyc("reset", 32'h0, 1'b0);
    chk("reset ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("reset ifid_instr", ifid_instr, 32'd0);
    chk("reset ifid_npc", ifid_npc, 32'd0);

    // Sequential fetch
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push(32'h0); cyc("seq0", 32'h0, 1'b1);
    push(32'h4); cyc("seq4", 32'h4, 1'b1);

    // Stall at pc=8: word goes to skid, IF/ID holds the word from 4
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0); push(32'h4); cyc("stall8", 32'h8, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0); push(32'h4); cyc("hold8", 32'h8, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0); push(32'h8); cyc("release8", 32'h8, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0); push(32'hC); cyc("after release", 32'hC, 1'b1);

    // Branch with flush
    branch_target = 32'h40;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1); cyc("branch", 32'h10, 1'b1);
    chk_bubble("branch");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0); cyc("branch target", 32'h40, 1'b1);
    chk_bubble("no hit");

    // Flush while in HOLD: skid dropped, refetch at the same pc
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0); cyc("stall40", 32'h40, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0); cyc("hold flush", 32'h40, 1'b0);
    chk_bubble("hold flush");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0); push(32'h40); cyc("refetch40", 32'h40, 1'b1);

    // Jump and jr redirects
    jump_target = 32'h100;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2); push(32'h44); cyc("jump", 32'h44, 1'b1);
    jr_target = 32'h200;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd3); cyc("jr", 32'h100, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0); cyc("jr target", 32'h200, 1'b1);

    // PC wrap at the top of the address space
    jump_target = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd2); cyc("to top", 32'h200, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0); push(32'hFFFF_FFFC); cyc("top", 32'hFFFF_FFFC, 1'b1);
    push(32'h0); cyc("wrap0", 32'h0, 1'b1);

    // Halt at pc=4
    halt = 1'b1; cyc("halt", 32'h4, 1'b1);
    halt = 1'b0;
    chk_bubble("halt");
    cyc("halted1", 32'h4, 1'b0);
    chk_bubble("halted1");
    cyc("halted2", 32'h4, 1'b0);

    // Reset out of HALTED, fetch resumes at PC_INIT
    RST = 1'b1; cyc("rst in halt", 32'h0, 1'b0);
    RST = 1'b0;
    push(32'h0); cyc("resume0", 32'h0, 1'b1);
    push(32'h4); cyc("resume4", 32'h4, 1'b1);

    // Enter HOLD with PC advancing, then reset inside HOLD
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0); push(32'h4); cyc("stall8b", 32'h8, 1'b1);
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); cyc("rst in hold", 32'h0, 1'b0);
    chk_bubble("rst in hold");
    chk("rst in hold ifid_npc", ifid_npc, 32'd0);
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0); cyc("post rst", 32'h0, 1'b1);
    chk_bubble("post rst");

    @(posedge CLK);
    #1;
    chk("expected queue drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
